// File: rtl/div.sv
// div -- 32-bit iterative radix-2 restoring divider (signed DIV / unsigned DIVU).
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed divide, 0 = unsigned; sampled when a start is accepted
//   opdata1_i     dividend; sampled when a start is accepted
//   opdata2_i     divisor; sampled when a start is accepted
//   start_i       request, held high until the result has been consumed
//   annul_i       flush request, cancels an operation in flight
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//
// Timing: acceptance edge 0, quotient steps on edges 1..32, sign correction and
// ready_o on edge 33. A divide by zero skips the loop and reports ready after edge 1.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2;
  logic [32:0] partial;
  logic [31:0] rem_sub;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes for acceptance; only signed requests negate negative inputs.
  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Shift {rem,quo} left by one: the 33-bit partial remainder picks up the quotient MSB.
  // After a successful subtract the value is below the divisor, so 32 bits suffice.
  assign partial = {rem_q, quo_q[31]};
  assign rem_sub = partial[31:0] - dvs_q;

  // Sign correction: quotient sign follows the operand signs, remainder follows the dividend.
  // The 0x80000000 / -1 case wraps naturally back to 0x80000000.
  assign quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

  // Next-state and datapath logic; everything holds unless a state says otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = 64'h0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'h0) begin
            state_d = BY_ZERO;
          end else begin
            state_d   = ON;
            cnt_d     = 6'd0;
            quo_d     = mag1;
            rem_d     = 32'h0;
            dvs_d     = mag2;
            neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d = signed_div_i & opdata1_i[31];
          end
        end
      end

      BY_ZERO: begin
        state_d  = END;
        result_d = 64'h0;
        ready_d  = 1'b1;
      end

      ON: begin
        if (annul_i) begin
          // Flush: drop the partial result entirely.
          state_d   = FREE;
          cnt_d     = 6'd0;
          quo_d     = 32'h0;
          rem_d     = 32'h0;
          dvs_d     = 32'h0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          result_d  = 64'h0;
          ready_d   = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_d  = END;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end else begin
          if (partial >= {1'b0, dvs_q}) begin
            rem_d = rem_sub;
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end

      END: begin
        // The result stays presented until the requester drops start_i.
        if (!start_i) begin
          state_d  = FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = FREE;
        result_d = 64'h0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= 6'd0;
      quo_q     <= 32'h0;
      rem_q     <= 32'h0;
      dvs_q     <= 32'h0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'h0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb_div -- directed bench for the div block.
// Inputs change on the falling edge and outputs are observed there as well.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int tests_run;
  int tests_failed;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, returning on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept an operation, scramble the operand inputs afterwards, and check
  // that ready is still low after edge 32 and the result appears after edge 33.
  task automatic apply_stimulus(input string tag, input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] exp);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    tick();
    op1        = $urandom;
    op2        = $urandom;
    signed_div = ~sgn;
    repeat (32) tick();
    check_output({tag, "_busy32"}, {63'b0, ready}, 64'd0);
    tick();
    check_output({tag, "_ready33"}, {63'b0, ready}, 64'd1);
    check_output({tag, "_result"}, result, exp);
  endtask

  // Drop start and expect the block to return to idle with cleared outputs.
  task automatic release_start(input string tag);
    start = 1'b0;
    tick();
    check_output({tag, "_rel_ready"}, {63'b0, ready}, 64'd0);
    check_output({tag, "_rel_result"}, result, 64'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    signed_div   = 1'b0;
    op1          = 32'h0;
    op2          = 32'h0;
    start        = 1'b0;
    annul        = 1'b0;

    #2;
    check_output("reset_ready", {63'b0, ready}, 64'd0);
    check_output("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Unsigned 100/7 with the result held while start stays high.
    apply_stimulus("udiv_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    repeat (2) tick();
    check_output("udiv_hold_ready", {63'b0, ready}, 64'd1);
    check_output("udiv_hold_result", result, 64'h00000002_0000000E);
    release_start("udiv_100_7");

    apply_stimulus("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    release_start("sdiv_m7_2");

    apply_stimulus("udiv_fff9_2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC);
    release_start("udiv_fff9_2");

    apply_stimulus("sdiv_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    release_start("sdiv_7_m2");

    apply_stimulus("sdiv_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    release_start("sdiv_ovf");

    apply_stimulus("udiv_max_1", 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF);
    release_start("udiv_max_1");

    // Divide by zero, with annul raised in BY_ZERO where it has no effect.
    signed_div = 1'b1;
    op1        = 32'd55;
    op2        = 32'd0;
    start      = 1'b1;
    tick();
    check_output("div0_edge0_ready", {63'b0, ready}, 64'd0);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check_output("div0_edge1_ready", {63'b0, ready}, 64'd1);
    check_output("div0_edge1_result", result, 64'd0);
    tick();
    check_output("div0_hold_ready", {63'b0, ready}, 64'd1);
    release_start("div0");

    signed_div = 1'b0;
    op1        = 32'd9;
    op2        = 32'd0;
    start      = 1'b1;
    repeat (2) tick();
    check_output("udiv0_ready", {63'b0, ready}, 64'd1);
    check_output("udiv0_result", result, 64'd0);
    release_start("udiv0");

    // Flush at edge 10, then a fresh 20/3 after one idle cycle.
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;
    start      = 1'b1;
    tick();
    repeat (9) tick();
    annul = 1'b1;
    tick();
    check_output("annul_ready", {63'b0, ready}, 64'd0);
    check_output("annul_result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    tick();
    apply_stimulus("udiv_20_3", 1'b0, 32'd20, 32'd3, 64'h00000002_00000006);
    release_start("udiv_20_3");

    // Asynchronous reset in the middle of the loop.
    signed_div = 1'b0;
    op1        = 32'd1000;
    op2        = 32'd3;
    start      = 1'b1;
    tick();
    repeat (15) tick();
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_mid_ready", {63'b0, ready}, 64'd0);
    check_output("rst_mid_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) tick();
    check_output("rst_mid_after_ready", {63'b0, ready}, 64'd0);

    // Asynchronous reset while a result is being held.
    apply_stimulus("udiv_1000_3", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D);
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_end_ready", {63'b0, ready}, 64'd0);
    check_output("rst_end_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    check_output("rst_end_after_ready", {63'b0, ready}, 64'd0);

    apply_stimulus("sdiv_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E);
    release_start("sdiv_m100_m7");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameters: none; data width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-004 signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled only at start acceptance.
REQ-005 opdata1_i  input  32  dividend; sampled only at start acceptance.
REQ-006 opdata2_i  input  32  divisor; sampled only at start acceptance.
REQ-007 start_i  input  1  request from EX stage; held high until EX consumes the result.
REQ-008 annul_i  input  1  abort request (pipeline flush); cancels the operation in flight.
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-010 ready_o  output  1  result valid; registered.

Function
REQ-011 The block SHALL implement an FSM with states FREE, BY_ZERO, ON and END, plus a 6-bit step counter cnt.
REQ-012 FREE, start_i=1, annul_i=0, opdata2_i=0: SHALL go to BY_ZERO (acceptance edge = edge 0).
REQ-013 FREE, start_i=1, annul_i=0, opdata2_i!=0: SHALL go to ON; cnt=0; latch the dividend and divisor magnitudes; when signed_div_i=1, negative operands SHALL be two's-complement negated; latch the sign flags.
REQ-014 FREE with start_i=0 or annul_i=1: SHALL remain in FREE with ready_o=0 and result_o=0.
REQ-015 BY_ZERO: SHALL go to END on the next edge with result_o=0 and ready_o=1, so ready_o is high after edge 1.
REQ-016 ON, annul_i=0: SHALL perform one radix-2 restoring step per edge (shift {rem,quo} left by 1, compare/subtract the 33-bit partial remainder, set the quotient LSB) and increment cnt; the 32 steps occur at edges 1..32.
REQ-017 ON, annul_i=0, cnt==32: SHALL apply sign correction and go to END with ready_o=1 at edge 33.
REQ-018 Sign correction (signed only): SHALL negate the quotient when the operand signs differ and SHALL negate the remainder when the dividend is negative; unsigned results SHALL be passed through unchanged.
REQ-019 Overflow case 0x80000000 / 0xFFFFFFFF (signed): SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-020 ON, annul_i=1: SHALL go to FREE on the next edge with ready_o=0 and result_o=0, discarding partial results.
REQ-021 annul_i SHALL be ignored in BY_ZERO and END.
REQ-022 END: while start_i=1, SHALL hold result_o and ready_o=1 unchanged.
REQ-023 END, start_i=0: SHALL go to FREE with ready_o=0 and result_o=0 on that edge.
REQ-024 Inputs other than start_i and annul_i SHALL NOT affect an operation after acceptance.
REQ-025 Back-to-back operations SHALL require at least one cycle in FREE between them.

Reset
REQ-026 While rst=0 (asynchronously, including mid-operation), the block SHALL force state=FREE, cnt=0, ready_o=0, result_o=64'h0 and all internal datapath registers to 0.
REQ-027 After rst deasserts, the first start SHALL be accepted on the first rising edge that sees start_i=1.

Verification
REQ-028 Unsigned 100/7, start held -> ready_o rises after edge 33; result_o=64'h00000002_0000000E; held until start_i=0.
REQ-029 Signed 0xFFFFFFF9/0x00000002 (-7/2) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 7/-2 -> 64'h00000001_FFFFFFFD.
REQ-030 Divisor 0, either signedness -> ready_o=1 after edge 1; result_o=0.
REQ-031 Signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000; unsigned 0xFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
REQ-032 annul_i pulsed at edge 10 of ON -> FREE, ready_o=0, result_o=0 next cycle; a new start (20/3) one cycle later -> 64'h00000002_00000006 after its edge 33.
REQ-033 rst driven low at edge 15 of ON (between edges) -> outputs zero immediately without a clock; after release, ready_o stays 0 until a new start completes.
